// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and defaults for the pipeline stall controller:
//               FSM state encoding, counter/timeout defaults, wait-counter
//               width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Controller FSM states (fixed encoding, visible in waveforms/debug)
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam int c_cnt_w_default       = 16;
    localparam int c_mem_timeout_default = 64;

    // Width needed for a counter that must be able to hold 'timeout'
    function automatic int wait_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_ctrl_if
// Description : Hazard/stall interface between the request sources (hazard
//               detection, branch unit, data memory, decoder) and the stall
//               controller that drives the pipeline register controls.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_stall_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = c_cnt_w_default
);
    // Requests
    logic             load_use_stall;
    logic             branch_taken;
    logic             halt_req;
    logic             resume;
    logic             mem_req;
    logic             mem_ready;
    // Pipeline controls and status
    logic             pc_we;
    logic             if_id_we;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             pipe_freeze;
    logic             halted;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Request side: raises hazards, consumes the register controls
    modport master (
        output load_use_stall, branch_taken, halt_req, resume, mem_req, mem_ready,
        input  pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_flush,
               pipe_freeze, halted, mem_err, stall_cnt, flush_cnt
    );

    // Responder side: the stall controller
    modport slave (
        input  load_use_stall, branch_taken, halt_req, resume, mem_req, mem_ready,
        output pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_flush,
               pipe_freeze, halted, mem_err, stall_cnt, flush_cnt
    );

endinterface
`default_nettype wire

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter with increment enable that sticks at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_en,
    output logic      [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Count enabled cycles, holding once the maximum value is reached
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en && !(&r_count)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_ctrl
// Description : Pipeline stall/flush controller. Arbitrates memory wait,
//               branch squash, halt and load-use requests into PC / IF/ID
//               enables, stage flushes and a back-end freeze. Tracks a
//               memory-wait timeout and saturating stall/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W       = c_cnt_w_default,
    parameter int MEM_TIMEOUT = c_mem_timeout_default
) (
    input wire logic              clk,
    input wire logic              rst,
    pipeline_stall_ctrl_if.slave  bus
);

    localparam int WAIT_W = wait_width(MEM_TIMEOUT);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [WAIT_W-1:0]   w_wait_nxt;
    logic [WAIT_W-1:0]   w_wait_inc;
    logic                r_mem_err;
    logic                w_err_set;
    logic                w_timeout_hit;
    logic                w_pc_we;
    logic                w_if_id_we;
    logic                w_if_id_flush;
    logic                w_id_ex_flush;
    logic                w_ex_mem_flush;
    logic                w_pipe_freeze;
    logic                w_halted;
    logic [CNT_W-1:0]    w_stall_cnt;
    logic [CNT_W-1:0]    w_flush_cnt;

    // The first frozen cycle (in RUN) counts as wait cycle 1; later ones add 1
    assign w_wait_inc = (r_state != MEM_WAIT) ? WAIT_W'(1) :
                        (&r_wait_cnt)         ? r_wait_cnt : r_wait_cnt + 1'b1;

    generate
        if (MEM_TIMEOUT != 0) begin : g_timeout
            localparam logic [WAIT_W-1:0] c_timeout = WAIT_W'(MEM_TIMEOUT);
            assign w_timeout_hit = (w_wait_inc == c_timeout);
        end else begin : g_no_timeout
            assign w_timeout_hit = 1'b0;
        end
    endgenerate

    // State, wait counter and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_mem_err  <= r_mem_err | w_err_set;
        end
    end

    // Request arbitration: next state and raw pipeline controls
    always_comb begin
        w_pc_we        = 1'b0;
        w_if_id_we     = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_flush = 1'b0;
        w_pipe_freeze  = 1'b0;
        w_halted       = 1'b0;
        w_state_nxt    = r_state;
        w_wait_nxt     = r_wait_cnt;
        w_err_set      = 1'b0;
        case (r_state)
            RUN, MEM_WAIT: begin
                // In MEM_WAIT the access is outstanding regardless of mem_req
                if ((r_state == MEM_WAIT || bus.mem_req) && !bus.mem_ready) begin
                    w_pipe_freeze = 1'b1;
                    w_wait_nxt    = w_wait_inc;
                    if (w_timeout_hit) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = HALT;
                    end else begin
                        w_state_nxt = MEM_WAIT;
                    end
                end else if (bus.branch_taken) begin
                    // Squash younger instructions; halt/load-use die with them
                    w_pc_we        = 1'b1;
                    w_if_id_we     = 1'b1;
                    w_if_id_flush  = 1'b1;
                    w_id_ex_flush  = 1'b1;
                    w_ex_mem_flush = 1'b1;
                    w_state_nxt    = RUN;
                end else if (bus.halt_req) begin
                    w_id_ex_flush = 1'b1;
                    w_state_nxt   = HALT;
                end else if (bus.load_use_stall) begin
                    w_id_ex_flush = 1'b1;
                    w_state_nxt   = RUN;
                end else begin
                    w_pc_we     = 1'b1;
                    w_if_id_we  = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            HALT: begin
                // Front end held, older instructions keep draining
                w_id_ex_flush = 1'b1;
                w_halted      = 1'b1;
                if (bus.resume) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // Performance counters: cycles without PC update, cycles flushing IF/ID
    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_en    (~w_pc_we),
        .o_count (w_stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_if_id_flush),
        .o_count (w_flush_cnt)
    );

    // All controls forced low while reset is held
    assign bus.pc_we        = w_pc_we        & ~rst;
    assign bus.if_id_we     = w_if_id_we     & ~rst;
    assign bus.if_id_flush  = w_if_id_flush  & ~rst;
    assign bus.id_ex_flush  = w_id_ex_flush  & ~rst;
    assign bus.ex_mem_flush = w_ex_mem_flush & ~rst;
    assign bus.pipe_freeze  = w_pipe_freeze  & ~rst;
    assign bus.halted       = w_halted       & ~rst;
    assign bus.mem_err      = r_mem_err;
    assign bus.stall_cnt    = w_stall_cnt;
    assign bus.flush_cnt    = w_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_stall_ctrl
// Description : Directed self-checking bench for pipeline_stall_ctrl.
//               Control vector order: {pc_we, if_id_we, if_id_flush,
//               id_ex_flush, ex_mem_flush, pipe_freeze, halted}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_ctrl;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 4;

    localparam logic [6:0] c_ctl_zero   = 7'b0000000;
    localparam logic [6:0] c_ctl_idle   = 7'b1100000;
    localparam logic [6:0] c_ctl_stall  = 7'b0001000;
    localparam logic [6:0] c_ctl_branch = 7'b1111100;
    localparam logic [6:0] c_ctl_freeze = 7'b0000010;
    localparam logic [6:0] c_ctl_halt   = 7'b0001001;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_stall_ctrl #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [6:0] ctl;
    assign ctl = {bus.pc_we, bus.if_id_we, bus.if_id_flush, bus.id_ex_flush,
                  bus.ex_mem_flush, bus.pipe_freeze, bus.halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        bus.load_use_stall = 1'b0;
        bus.branch_taken   = 1'b0;
        bus.halt_req       = 1'b0;
        bus.resume         = 1'b0;
        bus.mem_req        = 1'b0;
        bus.mem_ready      = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        #1;
        total++;
        if (ctl !== c_ctl_zero) begin
            bad++; $display("FAIL reset_ctl: got %b want %b", ctl, c_ctl_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (ctl !== c_ctl_idle) begin
            bad++; $display("FAIL idle_ctl: got %b want %b", ctl, c_ctl_idle);
        end
        total++;
        if ({bus.stall_cnt, bus.flush_cnt, bus.mem_err} !== {4'd0, 4'd0, 1'b0}) begin
            bad++; $display("FAIL idle_counters: got stall=%0d flush=%0d err=%b want 0 0 0",
                            bus.stall_cnt, bus.flush_cnt, bus.mem_err);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        @(negedge clk);
        bus.load_use_stall = 1'b1;
        #1;
        total++;
        if (ctl !== c_ctl_stall) begin
            bad++; $display("FAIL load_use_ctl: got %b want %b", ctl, c_ctl_stall);
        end
        @(negedge clk);
        bus.load_use_stall = 1'b0;
        #1;
        total++;
        if (ctl !== c_ctl_idle) begin
            bad++; $display("FAIL load_use_release: got %b want %b", ctl, c_ctl_idle);
        end
        total++;
        if (bus.stall_cnt !== 4'd1) begin
            bad++; $display("FAIL load_use_cnt: got %0d want 1", bus.stall_cnt);
        end
    endtask

    task automatic test_branch_priority();
        apply_reset();
        @(negedge clk);
        bus.branch_taken   = 1'b1;
        bus.load_use_stall = 1'b1;
        bus.halt_req       = 1'b1;
        #1;
        total++;
        if (ctl !== c_ctl_branch) begin
            bad++; $display("FAIL branch_ctl: got %b want %b", ctl, c_ctl_branch);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        total++;
        if (ctl !== c_ctl_idle) begin
            bad++; $display("FAIL branch_after_ctl: got %b want %b", ctl, c_ctl_idle);
        end
        total++;
        if ({bus.flush_cnt, bus.stall_cnt} !== {4'd1, 4'd0}) begin
            bad++; $display("FAIL branch_cnt: got flush=%0d stall=%0d want 1 0",
                            bus.flush_cnt, bus.stall_cnt);
        end
    endtask

    task automatic test_mem_wait();
        apply_reset();
        @(negedge clk);
        bus.mem_req   = 1'b1;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (ctl !== c_ctl_freeze) begin
                bad++; $display("FAIL mem_wait_ctl[%0d]: got %b want %b", i, ctl, c_ctl_freeze);
            end
            @(negedge clk);
        end
        bus.mem_ready = 1'b1;
        #1;
        total++;
        if (ctl !== c_ctl_idle) begin
            bad++; $display("FAIL mem_ready_ctl: got %b want %b", ctl, c_ctl_idle);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        total++;
        if ({bus.stall_cnt, bus.mem_err, bus.halted} !== {4'd3, 1'b0, 1'b0}) begin
            bad++; $display("FAIL mem_wait_cnt: got stall=%0d err=%b halted=%b want 3 0 0",
                            bus.stall_cnt, bus.mem_err, bus.halted);
        end
    endtask

    task automatic test_mem_ready_branch();
        apply_reset();
        @(negedge clk);
        bus.mem_req = 1'b1;
        @(negedge clk);
        bus.mem_ready    = 1'b1;
        bus.branch_taken = 1'b1;
        #1;
        total++;
        if (ctl !== c_ctl_branch) begin
            bad++; $display("FAIL mem_ready_branch_ctl: got %b want %b", ctl, c_ctl_branch);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        total++;
        if (ctl !== c_ctl_idle) begin
            bad++; $display("FAIL mem_ready_branch_after: got %b want %b", ctl, c_ctl_idle);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        @(negedge clk);
        bus.mem_req   = 1'b1;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            #1;
            total++;
            if (ctl !== c_ctl_freeze || bus.mem_err !== 1'b0) begin
                bad++; $display("FAIL timeout_wait[%0d]: got ctl=%b err=%b want %b 0",
                                i, ctl, bus.mem_err, c_ctl_freeze);
            end
            @(negedge clk);
        end
        #1;
        total++;
        if ({ctl, bus.mem_err, bus.stall_cnt} !== {c_ctl_halt, 1'b1, 4'd4}) begin
            bad++; $display("FAIL timeout_halt: got ctl=%b err=%b stall=%0d want %b 1 4",
                            ctl, bus.mem_err, bus.stall_cnt, c_ctl_halt);
        end
        bus.resume = 1'b1;
        #1;
        total++;
        if (ctl !== c_ctl_halt) begin
            bad++; $display("FAIL resume_cycle_ctl: got %b want %b", ctl, c_ctl_halt);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        total++;
        if ({ctl, bus.mem_err, bus.stall_cnt} !== {c_ctl_idle, 1'b1, 4'd5}) begin
            bad++; $display("FAIL resume_run: got ctl=%b err=%b stall=%0d want %b 1 5",
                            ctl, bus.mem_err, bus.stall_cnt, c_ctl_idle);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        @(negedge clk);
        bus.load_use_stall = 1'b1;
        repeat (20) @(negedge clk);
        bus.load_use_stall = 1'b0;
        #1;
        total++;
        if ({bus.stall_cnt, bus.flush_cnt} !== {4'd15, 4'd0}) begin
            bad++; $display("FAIL stall_saturate: got stall=%0d flush=%0d want 15 0",
                            bus.stall_cnt, bus.flush_cnt);
        end
        bus.branch_taken = 1'b1;
        repeat (17) @(negedge clk);
        #1;
        total++;
        if ({ctl, bus.flush_cnt, bus.stall_cnt} !== {c_ctl_branch, 4'd15, 4'd15}) begin
            bad++; $display("FAIL flush_saturate: got ctl=%b flush=%0d stall=%0d want %b 15 15",
                            ctl, bus.flush_cnt, bus.stall_cnt, c_ctl_branch);
        end
        clear_inputs();
    endtask

    task automatic test_halt_async_reset();
        apply_reset();
        @(negedge clk);
        bus.halt_req = 1'b1;
        #1;
        total++;
        if (ctl !== c_ctl_stall) begin
            bad++; $display("FAIL halt_req_ctl: got %b want %b", ctl, c_ctl_stall);
        end
        @(negedge clk);
        bus.halt_req = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            #1;
            total++;
            if (ctl !== c_ctl_halt) begin
                bad++; $display("FAIL halt_hold[%0d]: got %b want %b", k, ctl, c_ctl_halt);
            end
            if (k < 10) @(negedge clk);
        end
        total++;
        if (bus.stall_cnt !== 4'd10) begin
            bad++; $display("FAIL halt_stall_cnt: got %0d want 10", bus.stall_cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({ctl, bus.stall_cnt, bus.flush_cnt, bus.mem_err} !== {c_ctl_zero, 4'd0, 4'd0, 1'b0}) begin
            bad++; $display("FAIL async_reset: got ctl=%b stall=%0d flush=%0d err=%b want %b 0 0 0",
                            ctl, bus.stall_cnt, bus.flush_cnt, bus.mem_err, c_ctl_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (ctl !== c_ctl_idle) begin
            bad++; $display("FAIL after_reset_run: got %b want %b", ctl, c_ctl_idle);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_branch_priority();
        test_mem_wait();
        test_mem_ready_branch();
        test_timeout();
        test_saturation();
        test_halt_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
